// File: rtl/tqvp_prism_loader.sv
// PRISM configuration loader: halts PRISM, replays queued (addr, data) writes
// with a minimum spacing, then re-enables it. Core writes always take the port.
module tqvp_prism_loader #(
    parameter int DEPTH = 4,
    parameter int GAP   = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cpu_wr_i,
    input  logic [5:0]  cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic        ld_push_i,
    input  logic [5:0]  ld_addr_i,
    input  logic [31:0] ld_data_i,
    input  logic        ld_start_i,
    input  logic [31:0] run_ctrl_i,
    output logic        ld_full_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        p_wr_o,
    output logic [5:0]  p_addr_o,
    output logic [31:0] p_wdata_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_WAIT,
        S_POP,
        S_FINAL,
        S_DONE
    } state_e;

    state_e      state_q;
    logic [GW-1:0] gap_q, gap_d;
    logic        halted_q;
    logic        final_q;
    logic [31:0] run_ctrl_q;
    logic        err_q, err_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [5:0]  mem_addr_q [DEPTH];
    logic [31:0] mem_data_q [DEPTH];

    logic        issue_state;
    logic        issue;
    logic        pop;
    logic        push_ok;
    logic        drop;
    logic        full;
    logic        start_ok;
    logic [5:0]  ld_addr_mux;
    logic [31:0] ld_data_mux;

    assign full        = (count_q == CW'(DEPTH));
    assign start_ok    = (state_q == S_IDLE) && ld_start_i;
    assign issue_state = (state_q == S_HALT) || (state_q == S_POP) || (state_q == S_FINAL);
    // An issue slot is only usable when the core is silent and the spacing has elapsed.
    assign issue       = issue_state && !cpu_wr_i && (gap_q == '0);
    assign pop         = (state_q == S_POP) && issue;
    assign push_ok     = ld_push_i && (!full || pop);
    assign drop        = ld_push_i && full && !pop;

    always_comb begin
        ld_addr_mux = 6'h00;
        ld_data_mux = 32'h0000_0000;
        case (state_q)
            S_POP: begin
                ld_addr_mux = mem_addr_q[rd_ptr_q];
                ld_data_mux = mem_data_q[rd_ptr_q];
            end
            S_FINAL: ld_data_mux = run_ctrl_q;
            default: ;
        endcase
    end

    always_comb begin
        p_wr_o    = cpu_wr_i | issue;
        p_addr_o  = cpu_wr_i ? cpu_addr_i  : (issue ? ld_addr_mux : 6'h00);
        p_wdata_o = cpu_wr_i ? cpu_wdata_i : (issue ? ld_data_mux : 32'h0000_0000);
    end

    always_comb begin
        gap_d = gap_q;
        if (p_wr_o) begin
            gap_d = GW'(GAP - 1);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        err_d = err_q;
        if (drop) begin
            err_d = 1'b1;
        end else if (start_ok) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            gap_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage has no reset; the read pointer only reaches slots that were written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_addr_q[wr_ptr_q] <= ld_addr_i;
            mem_data_q[wr_ptr_q] <= ld_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            halted_q   <= 1'b0;
            final_q    <= 1'b0;
            run_ctrl_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ld_start_i) begin
                        run_ctrl_q <= run_ctrl_i;
                        halted_q   <= 1'b0;
                        final_q    <= 1'b0;
                        state_q    <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (issue) begin
                        halted_q <= 1'b1;
                    end
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Leave one cycle early so the next issue lands exactly GAP after the last write.
                    if (!p_wr_o && (gap_q <= GW'(1))) begin
                        if (!halted_q) begin
                            state_q <= S_HALT;
                        end else if (count_q != '0) begin
                            state_q <= S_POP;
                        end else if (!final_q) begin
                            state_q <= S_FINAL;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_POP: begin
                    state_q <= S_WAIT;
                end
                S_FINAL: begin
                    if (issue) begin
                        final_q <= 1'b1;
                    end
                    state_q <= S_WAIT;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ld_full_o = full;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign err_o     = err_q;

endmodule

// File: tb/tb_tqvp_prism_loader.sv
// Scoreboard bench for tqvp_prism_loader: every expected PRISM port write is
// queued with its cycle and matched against the port as writes appear.
module tb_tqvp_prism_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_wr;
    logic [5:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        ld_push;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_start;
    logic [31:0] run_ctrl;
    logic        ld_full;
    logic        busy;
    logic        done;
    logic        err;
    logic        p_wr;
    logic [5:0]  p_addr;
    logic [31:0] p_wdata;

    tqvp_prism_loader #(.DEPTH(4), .GAP(3)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cpu_wr_i    (cpu_wr),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .ld_push_i   (ld_push),
        .ld_addr_i   (ld_addr),
        .ld_data_i   (ld_data),
        .ld_start_i  (ld_start),
        .run_ctrl_i  (run_ctrl),
        .ld_full_o   (ld_full),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .p_wr_o      (p_wr),
        .p_addr_o    (p_addr),
        .p_wdata_o   (p_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t expQ[$];
    int  base = 0;
    int  nChecks = 0;
    int  nFails = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every port write, loader or core, must match the head of the expectation queue.
    always @(negedge clk) begin
        if (p_wr === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", {63'd0, p_wr}, 64'd0);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("wrCycle", 64'(cyc - base), 64'(e.cyc - base));
                checkOutput("wrAddr", {58'd0, p_addr}, {58'd0, e.addr});
                checkOutput("wrData", {32'd0, p_wdata}, {32'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitTo(input int k);
        while (cyc < base + k) tick();
    endtask

    task automatic expectWrite(input logic [5:0] a, input logic [31:0] d, input int k);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = base + k;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [5:0] a, input logic [31:0] d);
        ld_push = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_push = 1'b0;
    endtask

    task automatic startLoad(input logic [31:0] ctrl);
        ld_start = 1'b1;
        run_ctrl = ctrl;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic checkEnd(input string tag, input int doneCyc);
        waitTo(doneCyc - 1);
        checkOutput({tag, "_doneEarly"}, {63'd0, done}, 64'd0);
        waitTo(doneCyc);
        checkOutput({tag, "_done"}, {63'd0, done}, 64'd1);
        checkOutput({tag, "_busyDone"}, {63'd0, busy}, 64'd1);
        waitTo(doneCyc + 1);
        checkOutput({tag, "_doneAfter"}, {63'd0, done}, 64'd0);
        checkOutput({tag, "_busyAfter"}, {63'd0, busy}, 64'd0);
        checkOutput({tag, "_sbEmpty"}, 64'(expQ.size()), 64'd0);
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = 6'h00;
        cpu_wdata = 32'h0;
        ld_push   = 1'b0;
        ld_addr   = 6'h00;
        ld_data   = 32'h0;
        ld_start  = 1'b0;
        run_ctrl  = 32'h0;

        tick();
        tick();
        checkOutput("rst_full", {63'd0, ld_full}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_err", {63'd0, err}, 64'd0);
        checkOutput("rst_pwr", {63'd0, p_wr}, 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        $display("[TB] two-entry load");
        applyStimulus(6'h08, 32'h1111_1111);
        applyStimulus(6'h0C, 32'h2222_2222);
        base = cyc;
        expectWrite(6'h00, 32'h0000_0000, 1);
        expectWrite(6'h08, 32'h1111_1111, 4);
        expectWrite(6'h0C, 32'h2222_2222, 7);
        expectWrite(6'h00, 32'h2000_0000, 10);
        startLoad(32'h2000_0000);
        checkOutput("two_busy1", {63'd0, busy}, 64'd1);
        checkEnd("two", 13);

        $display("[TB] empty load");
        base = cyc;
        expectWrite(6'h00, 32'h0000_0000, 1);
        expectWrite(6'h00, 32'h8000_0001, 4);
        startLoad(32'h8000_0001);
        checkEnd("empty", 7);

        $display("[TB] core write during load");
        applyStimulus(6'h08, 32'h1111_1111);
        applyStimulus(6'h0C, 32'h2222_2222);
        base = cyc;
        expectWrite(6'h00, 32'h0000_0000, 1);
        expectWrite(6'h18, 32'h0000_00AB, 4);
        expectWrite(6'h08, 32'h1111_1111, 7);
        expectWrite(6'h0C, 32'h2222_2222, 10);
        expectWrite(6'h00, 32'h2000_0000, 13);
        startLoad(32'h2000_0000);
        waitTo(4);
        cpu_wr    = 1'b1;
        cpu_addr  = 6'h18;
        cpu_wdata = 32'h0000_00AB;
        tick();
        cpu_wr = 1'b0;
        checkEnd("core", 16);

        $display("[TB] overflow");
        for (int i = 0; i < 4; i++) applyStimulus(6'(6'h20 + i), 32'hA000_0000 + 32'(i));
        checkOutput("ovf_full4", {63'd0, ld_full}, 64'd1);
        checkOutput("ovf_err4", {63'd0, err}, 64'd0);
        applyStimulus(6'h3F, 32'hDEAD_BEEF);
        checkOutput("ovf_full5", {63'd0, ld_full}, 64'd1);
        checkOutput("ovf_err5", {63'd0, err}, 64'd1);
        base = cyc;
        expectWrite(6'h00, 32'h0000_0000, 1);
        for (int i = 0; i < 4; i++) expectWrite(6'(6'h20 + i), 32'hA000_0000 + 32'(i), 4 + 3 * i);
        expectWrite(6'h00, 32'h4000_0000, 16);
        startLoad(32'h4000_0000);
        checkOutput("ovf_errClr", {63'd0, err}, 64'd0);
        checkEnd("ovf", 19);

        $display("[TB] reset mid-load");
        applyStimulus(6'h08, 32'h1111_1111);
        applyStimulus(6'h0C, 32'h2222_2222);
        base = cyc;
        expectWrite(6'h00, 32'h0000_0000, 1);
        expectWrite(6'h08, 32'h1111_1111, 4);
        startLoad(32'h2000_0000);
        waitTo(5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("mid_busy", {63'd0, busy}, 64'd0);
        checkOutput("mid_done", {63'd0, done}, 64'd0);
        checkOutput("mid_pwr", {63'd0, p_wr}, 64'd0);
        repeat (8) tick();
        checkOutput("mid_sbEmpty", 64'(expQ.size()), 64'd0);
        base = cyc;
        expectWrite(6'h00, 32'h0000_0000, 1);
        expectWrite(6'h00, 32'h1234_5678, 4);
        startLoad(32'h1234_5678);
        checkEnd("post", 7);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
